// File: rtl/led_pkg.sv
// Shared types and helpers for the WS2801 LED drivers.
package led_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    typedef enum logic [1:0] {
        ORDER_RGB,
        ORDER_GRB,
        ORDER_BGR
    } order_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } state_e;

    // Latch gap in clk cycles; 64-bit intermediate because FREQ*us overflows 32 bits.
    function automatic int latch_cycles(input longint freq, input longint us);
        return int'((freq * us) / longint'(1_000_000));
    endfunction

    // Arrange the three colour bytes in the order the strip expects on the wire.
    function automatic logic [23:0] reorder(input color_t c, input order_e ord);
        case (ord)
            ORDER_GRB: return {c.g, c.r, c.b};
            ORDER_BGR: return {c.b, c.g, c.r};
            default:   return {c.r, c.g, c.b};
        endcase
    endfunction

endpackage

// File: rtl/ws2801_shifter.sv
// Serialises one 24-bit pixel word, MSB first, onto the WS2801 data/clock pair.
// dOut is updated only on the clkOut falling edge (or at load, while clkOut is low).
module ws2801_shifter #(
    parameter int FREQ_DIV = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] word,
    output logic        ready,
    output logic        dOut,
    output logic        clkOut,
    output logic        word_done
);
    localparam int DIV_W = $clog2(FREQ_DIV) + 1;

    logic             active;
    logic             tick;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [23:0]      sreg;

    assign tick      = active && (div_cnt == DIV_W'(FREQ_DIV - 1));
    assign ready     = !active;
    assign word_done = tick && clkOut && (bit_cnt == 5'd0);

    // Half-period divider, clock toggling and bit sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            dOut    <= 1'b0;
            clkOut  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (load && !active) begin
            active  <= 1'b1;
            dOut    <= word[23];
            clkOut  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= 5'd23;
        end else if (active) begin
            if (tick) begin
                div_cnt <= '0;
                if (!clkOut) begin
                    clkOut <= 1'b1;
                end else begin
                    clkOut <= 1'b0;
                    if (bit_cnt == 5'd0) begin
                        active <= 1'b0;
                        dOut   <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                        dOut    <= sreg[22];
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Word register shifts left after each completed bit
    always_ff @(posedge clk) begin
        if (load && !active)
            sreg <= word;
        else if (tick && clkOut)
            sreg <= {sreg[22:0], 1'b0};
    end

endmodule

// File: rtl/ws2801_bin_driver.sv
// Builds a WS2801 frame from colour bins: bin k paints LEDCounts[k] LEDs,
// scaled by a global brightness, zero-filled or truncated to exactly LEDS pixels.
module ws2801_bin_driver
    import led_pkg::*;
#(
    parameter int     LEDS        = 50,
    parameter int     BIN_QTY     = 12,
    parameter int     FREQ        = 12_500_000,
    parameter int     FREQ_DIV    = 5,
    parameter int     LATCH_US    = 500,
    parameter int     BRIGHT_W    = 8,
    parameter order_e COLOR_ORDER = ORDER_RGB
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 repeat_en,
    input  logic [BIN_QTY-1:0][23:0]             rgb,
    input  logic [BIN_QTY-1:0][$clog2(LEDS)-1:0] LEDCounts,
    input  logic [BRIGHT_W-1:0]                  brightness,
    output logic                                 dOut,
    output logic                                 clkOut,
    output logic                                 done,
    output logic                                 busy
);
    localparam int CNT_W     = $clog2(LEDS);
    localparam int IDX_W     = $clog2(LEDS + 1);
    localparam int BIN_W     = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
    localparam int LATCH_CYC = latch_cycles(FREQ, LATCH_US);
    localparam int LAT_W     = $clog2(LATCH_CYC + 1);
    localparam int P_W       = BRIGHT_W + 9;

    // (c * (b+1)) >> BRIGHT_W; full-scale brightness passes the channel unchanged.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [BRIGHT_W-1:0] b);
        logic [P_W-1:0] p;
        p = P_W'(c) * (P_W'(b) + P_W'(1));
        return p[BRIGHT_W +: 8];
    endfunction

    state_e                        state, state_n;
    logic [BIN_QTY-1:0][23:0]      rgb_q;
    logic [BIN_QTY-1:0][CNT_W-1:0] cnt_q;
    logic [BRIGHT_W-1:0]           bri_q;
    logic [IDX_W-1:0]              led_idx;
    logic [BIN_W-1:0]              bin_idx, sel;
    logic [CNT_W-1:0]              bin_rem, sel_rem, cand;
    logic [LAT_W-1:0]              latch_cnt;
    logic                          found, snap, last_led;
    logic                          sh_load, sh_ready, word_done;
    color_t                        px, sc;
    logic [23:0]                   word;

    assign last_led = (led_idx == IDX_W'(LEDS));

    // First bin at or after the current one that still has LEDs left to paint
    always_comb begin
        found   = 1'b0;
        sel     = bin_idx;
        sel_rem = '0;
        cand    = '0;
        for (int b = BIN_QTY - 1; b >= 0; b--) begin
            cand = (BIN_W'(b) == bin_idx) ? bin_rem : cnt_q[b];
            if (BIN_W'(b) >= bin_idx && cand != '0) begin
                found   = 1'b1;
                sel     = BIN_W'(b);
                sel_rem = cand;
            end
        end
    end

    // Pixel word for the current LED: black once all bins are exhausted
    always_comb begin
        px   = found ? color_t'(rgb_q[sel]) : color_t'(24'h000000);
        sc.r = scale(px.r, bri_q);
        sc.g = scale(px.g, bri_q);
        sc.b = scale(px.b, bri_q);
        word = reorder(sc, COLOR_ORDER);
    end

    // Next-state decode, shifter load strobe and input snapshot strobe
    always_comb begin
        state_n = state;
        sh_load = 1'b0;
        snap    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    snap    = 1'b1;
                end
            end
            LOAD: begin
                sh_load = 1'b1;
                if (sh_ready) state_n = SHIFT;
            end
            SHIFT: begin
                if (word_done) state_n = last_led ? LATCH : LOAD;
            end
            LATCH: begin
                if (latch_cnt == '0) begin
                    if (repeat_en) begin
                        state_n = LOAD;
                        snap    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; done/busy registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= (state_n == IDLE);
            busy  <= (state_n != IDLE);
        end
    end

    // Frame inputs are frozen at each frame start
    always_ff @(posedge clk) begin
        if (snap) begin
            rgb_q <= rgb;
            cnt_q <= LEDCounts;
            bri_q <= brightness;
        end
    end

    // LED index, bin walk and latch gap counters
    always_ff @(posedge clk) begin
        if (rst) begin
            led_idx   <= '0;
            bin_idx   <= '0;
            bin_rem   <= '0;
            latch_cnt <= '0;
        end else begin
            if (snap) begin
                led_idx <= '0;
                bin_idx <= '0;
                bin_rem <= LEDCounts[0];
            end else if (state == LOAD && sh_ready) begin
                led_idx <= led_idx + IDX_W'(1);
                if (found) begin
                    bin_idx <= sel;
                    bin_rem <= sel_rem - CNT_W'(1);
                end
            end
            if (state == SHIFT && word_done && last_led)
                latch_cnt <= LAT_W'(LATCH_CYC - 1);
            else if (state == LATCH && latch_cnt != '0)
                latch_cnt <= latch_cnt - LAT_W'(1);
        end
    end

    ws2801_shifter #(
        .FREQ_DIV(FREQ_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .word     (word),
        .ready    (sh_ready),
        .dOut     (dOut),
        .clkOut   (clkOut),
        .word_done(word_done)
    );

endmodule

// File: tb/tb_ws2801_bin_driver.sv
// Directed bench for ws2801_bin_driver: decodes the serial stream back into LEDs.
module tb_ws2801_bin_driver;
    import led_pkg::*;

    localparam int LEDS      = 50;
    localparam int BQ        = 12;
    localparam int FD        = 2;
    localparam int FREQ      = 100_000;
    localparam int LUS       = 500;
    localparam int LATCH_CYC = 50;                    // 100 kHz * 500 us
    localparam int FRAME     = LEDS * (48 * FD + 1) + LATCH_CYC;
    localparam int NBITS     = LEDS * 24;

    logic                clk = 1'b0;
    logic                rst, start, repeat_en;
    logic [BQ-1:0][23:0] rgb;
    logic [BQ-1:0][5:0]  cnts;
    logic [7:0]          bri;
    logic                dout, cout, done, busy;
    logic                dout2, cout2, done2, busy2;

    ws2801_bin_driver #(
        .LEDS(LEDS), .BIN_QTY(BQ), .FREQ(FREQ), .FREQ_DIV(FD),
        .LATCH_US(LUS), .BRIGHT_W(8), .COLOR_ORDER(ORDER_RGB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .repeat_en(repeat_en),
        .rgb(rgb), .LEDCounts(cnts), .brightness(bri),
        .dOut(dout), .clkOut(cout), .done(done), .busy(busy)
    );

    ws2801_bin_driver #(
        .LEDS(LEDS), .BIN_QTY(BQ), .FREQ(FREQ), .FREQ_DIV(FD),
        .LATCH_US(LUS), .BRIGHT_W(8), .COLOR_ORDER(ORDER_GRB)
    ) dut_grb (
        .clk(clk), .rst(rst), .start(start), .repeat_en(repeat_en),
        .rgb(rgb), .LEDCounts(cnts), .brightness(bri),
        .dOut(dout2), .clkOut(cout2), .done(done2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Strip model: every rising clkOut shifts one bit in
    logic bitmem  [16384];
    logic bitmem2 [16384];
    int   nrise  = 0;
    int   nrise2 = 0;

    always @(posedge cout) begin
        bitmem[nrise % 16384] = dout;
        nrise = nrise + 1;
    end

    always @(posedge cout2) begin
        bitmem2[nrise2 % 16384] = dout2;
        nrise2 = nrise2 + 1;
    end

    // Data must not move while the serial clock is high
    int   viol = 0;
    logic pd = 1'b0, pc = 1'b0;
    always @(negedge clk) begin
        if (pc && cout && (dout != pd)) viol = viol + 1;
        pd = dout;
        pc = cout;
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] led_at(input bit second, input int base, input int k);
        logic [23:0] w;
        w = '0;
        for (int i = 0; i < 24; i++)
            w = {w[22:0], second ? bitmem2[(base + 24 * k + i) % 16384]
                                 : bitmem[(base + 24 * k + i) % 16384]};
        return w;
    endfunction

    task automatic chk_leds(input int base, input int lo, input int hi, input logic [23:0] exp);
        for (int k = lo; k <= hi; k++)
            chk($sformatf("led%0d", k), 32'(led_at(1'b0, base, k)), 32'(exp));
    endtask

    task automatic run_frame(output int base);
        int cyc;
        base = nrise;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("done_fall", 32'(done), 32'd0);
        chk("busy_rise", 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < FRAME + 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("frame_len", 32'(cyc), 32'(FRAME));
        chk("rise_cnt", 32'(nrise - base), 32'(NBITS));
    endtask

    task automatic wait_bits(input int target, inout bit seen);
        int cyc;
        cyc = 0;
        while (nrise < target && cyc < 3 * FRAME) begin
            @(negedge clk);
            seen = seen | done;
            cyc++;
        end
        chk("bits_reached", 32'(nrise >= target), 32'd1);
    endtask

    initial begin
        int b, b2, cyc;
        bit seen;

        rst = 1'b1; start = 1'b0; repeat_en = 1'b0;
        rgb = '0; cnts = '0; bri = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_clkout", 32'(cout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("done_after_rst", 32'(done), 32'd1);
        chk("busy_after_rst", 32'(busy), 32'd0);

        // Three bins of 10 then zero fill
        rgb[0] = 24'hFFFFFF; rgb[1] = 24'hF0F0F0; rgb[2] = 24'hAAAAAA;
        cnts[0] = 6'd10; cnts[1] = 6'd10; cnts[2] = 6'd10;
        run_frame(b);
        chk_leds(b, 0, 9, 24'hFFFFFF);
        chk_leds(b, 10, 19, 24'hF0F0F0);
        chk_leds(b, 20, 29, 24'hAAAAAA);
        chk_leds(b, 30, 49, 24'h000000);

        // Half brightness, then zero brightness
        rgb = '0; cnts = '0;
        rgb[0] = 24'h804020; cnts[0] = 6'd50; bri = 8'h7F;
        run_frame(b);
        chk_leds(b, 0, 49, 24'h402010);
        bri = 8'h00;
        run_frame(b);
        chk_leds(b, 0, 49, 24'h000000);

        // Byte order: RGB instance vs GRB instance
        bri = 8'hFF; rgb[0] = 24'h112233; cnts[0] = 6'd5;
        b2 = nrise2;
        run_frame(b);
        chk("grb_word", 32'(led_at(1'b1, b2, 0)), 32'h00221133);
        chk_leds(b, 0, 4, 24'h112233);
        chk_leds(b, 5, 49, 24'h000000);

        // Empty bin skipped, overflow truncated at LEDS
        rgb = '0; cnts = '0;
        rgb[0] = 24'h0000FF; cnts[0] = 6'd40;
        rgb[1] = 24'h123456; cnts[1] = 6'd0;
        rgb[2] = 24'h00FF00; cnts[2] = 6'd40;
        rgb[3] = 24'hFFFFFF; cnts[3] = 6'd5;
        run_frame(b);
        chk_leds(b, 0, 39, 24'h0000FF);
        chk_leds(b, 40, 49, 24'h00FF00);

        // Repeat mode: new colours picked up at the latch boundary
        rgb = '0; cnts = '0;
        rgb[0] = 24'hFF0000; cnts[0] = 6'd25;
        rgb[1] = 24'h00FF00; cnts[1] = 6'd25;
        repeat_en = 1'b1;
        b = nrise;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        seen = 1'b0;
        wait_bits(b + NBITS, seen);
        repeat (FD + 3) begin
            @(negedge clk);
            seen = seen | done;
        end
        chk("busy_in_latch", 32'(busy), 32'd1);
        rgb[0] = 24'h0000FF; rgb[1] = 24'hFFFFFF;
        wait_bits(b + NBITS + 300, seen);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = seen | done;
        repeat_en = 1'b0;
        wait_bits(b + 2 * NBITS, seen);
        chk("done_low_repeat", 32'(seen), 32'd0);
        cyc = 0;
        while (!done && cyc < FRAME) begin
            @(negedge clk);
            cyc++;
        end
        chk("repeat_done", 32'(done), 32'd1);
        chk_leds(b, 0, 24, 24'hFF0000);
        chk_leds(b, 25, 49, 24'h00FF00);
        chk_leds(b + NBITS, 0, 24, 24'h0000FF);
        chk_leds(b + NBITS, 25, 49, 24'hFFFFFF);
        repeat (20) @(negedge clk);
        chk("repeat_total_bits", 32'(nrise - b), 32'(2 * NBITS));
        chk("idle_after_repeat", 32'(done), 32'd1);

        // Reset in the middle of a frame, then a clean frame
        rgb = '0; cnts = '0;
        rgb[0] = 24'h5A5A5A; cnts[0] = 6'd50;
        b = nrise;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        seen = 1'b0;
        wait_bits(b + 300, seen);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_clkout", 32'(cout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_done_next", 32'(done), 32'd1);
        rgb[0] = 24'hC3C3C3;
        run_frame(b);
        chk_leds(b, 0, 49, 24'hC3C3C3);

        chk("dout_stable_clk_high", 32'(viol), 32'd0);
        chk("grb_done", 32'(done2), 32'd1);
        chk("grb_busy", 32'(busy2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
